// File: rtl/imm_decode_stage.sv
// imm_decode_stage: registered immediate generator with a two-entry skid buffer.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   flush_i                   drop all buffered entries
//   in_valid_i / in_ready_o   upstream handshake, in_ready_o = !skid valid
//   in_ir_i, in_pc_i          instruction word and its address
//   out_valid_o / out_ready_i downstream handshake
//   out_imm_o, out_fmt_o      extended immediate and format code
//   out_target_o              PC-relative target (pc+imm or pc+4)
//   out_illegal_o             unsupported opcode
//   err_count_o               saturating count of accepted illegal instructions
module imm_decode_stage #(
   parameter int XLEN     = 32,
   parameter bit SIGN_EXT = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [31:0]     in_ir_i,
   input  logic [XLEN-1:0] in_pc_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLEN-1:0] out_imm_o,
   output logic [2:0]      out_fmt_o,
   output logic [XLEN-1:0] out_target_o,
   output logic            out_illegal_o,
   output logic [15:0]     err_count_o
);
   localparam int EW = 2 * XLEN + 4;
   logic [6:0]      op;
   logic [2:0]      f3;
   logic            s, is_i, is_s, is_b, is_u, is_j, is_z, is_r, is_sh, ill, sx;
   logic [31:0]     imm32;
   logic [XLEN-1:0] imm, tgt;
   logic [2:0]      fmt;
   logic [EW-1:0]   new_e, main_q, main_d, skid_q, skid_d;
   logic            main_v_q, main_v_d, skid_v_q, skid_v_d, in_fire, out_fire;
   logic [15:0]     err_q, err_d;
   assign op    = in_ir_i[6:0];
   assign f3    = in_ir_i[14:12];
   assign s     = SIGN_EXT & in_ir_i[31];
   assign is_i  = op == 7'h03 || op == 7'h13 || op == 7'h67 || op == 7'h0F || (op == 7'h73 && !f3[2]);
   assign is_z  = op == 7'h73 && f3[2];
   assign is_s  = op == 7'h23;
   assign is_b  = op == 7'h63;
   assign is_u  = op == 7'h37 || op == 7'h17;
   assign is_j  = op == 7'h6F;
   assign is_r  = op == 7'h33;
   assign is_sh = op == 7'h13 && f3[1:0] == 2'b01;
   assign ill   = !(is_i | is_s | is_b | is_u | is_j | is_z | is_r);
   // Formats that carry ir[31] into the bits above 32 when XLEN=64.
   assign sx    = (is_i & !is_sh) | is_s | is_b | is_u | is_j;
   always_comb begin
      imm32 = is_sh ? {26'b0, in_ir_i[25] & (XLEN == 64), in_ir_i[24:20]}
            : is_i  ? {{20{s}}, in_ir_i[31:20]}
            : is_s  ? {{20{s}}, in_ir_i[31:25], in_ir_i[11:7]}
            : is_b  ? {{19{s}}, in_ir_i[31], in_ir_i[7], in_ir_i[30:25], in_ir_i[11:8], 1'b0}
            : is_u  ? {in_ir_i[31:12], 12'b0}
            : is_j  ? {{11{s}}, in_ir_i[31], in_ir_i[19:12], in_ir_i[20], in_ir_i[30:21], 1'b0}
            : is_z  ? {27'b0, in_ir_i[19:15]}
            : 32'b0;
      imm   = XLEN'(imm32) | ((sx & s) ? ~XLEN'(32'hFFFF_FFFF) : '0);
      fmt   = is_i ? 3'd1 : is_s ? 3'd2 : is_b ? 3'd3 : is_u ? 3'd4 : is_j ? 3'd5 : is_z ? 3'd6 : 3'd0;
      tgt   = in_pc_i + ((is_b | is_j | op == 7'h17) ? imm : XLEN'(4));
   end
   assign new_e    = {ill, fmt, tgt, imm};
   assign in_fire  = in_valid_i & ~skid_v_q;
   assign out_fire = main_v_q & out_ready_i;
   always_comb begin
      main_d   = main_q;
      skid_d   = skid_q;
      main_v_d = main_v_q;
      skid_v_d = skid_v_q;
      err_d    = err_q;
      if (flush_i) begin
         main_v_d = 1'b0;
         skid_v_d = 1'b0;
      end else begin
         if (out_fire) begin
            main_v_d = skid_v_q;
            main_d   = skid_v_q ? skid_q : main_q;
            skid_v_d = 1'b0;
         end
         // in_fire implies skid is empty, so the new entry goes to main
         // whenever main is empty or draining; otherwise it parks in skid.
         if (in_fire && (!main_v_q || out_fire)) begin
            main_d   = new_e;
            main_v_d = 1'b1;
         end else if (in_fire) begin
            skid_d   = new_e;
            skid_v_d = 1'b1;
         end
         err_d = (in_fire && ill && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         main_q   <= '0;
         skid_q   <= '0;
         main_v_q <= 1'b0;
         skid_v_q <= 1'b0;
         err_q    <= '0;
      end else begin
         main_q   <= main_d;
         skid_q   <= skid_d;
         main_v_q <= main_v_d;
         skid_v_q <= skid_v_d;
         err_q    <= err_d;
      end
   end
   assign {out_illegal_o, out_fmt_o, out_target_o, out_imm_o} = main_q;
   assign out_valid_o = main_v_q;
   assign in_ready_o  = ~skid_v_q;
   assign err_count_o = err_q;
endmodule
